// File: rtl/sr_latch_nor.sv
// sr_latch_nor: a synchronous model of WIDTH independent cross-coupled NOR SR latches.
// Each bit follows the NOR truth table on every rising clk edge. The S=R=1 state
// drives both outputs low. Holding out of that state resolves reset-dominant and
// raises a one-cycle race pulse. A saturating counter and a sticky flag record
// how many times any bit entered the forbidden state.
module sr_latch_nor #(
    parameter int WIDTH = 1,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] s,
    input  logic [WIDTH-1:0] r,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] q_bar,
    output logic [WIDTH-1:0] forbidden,
    output logic [WIDTH-1:0] race,
    output logic             err_sticky,
    output logic [CNT_W-1:0] forbid_cnt
);

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic [WIDTH-1:0] q_next;
    logic [WIDTH-1:0] q_bar_next;
    logic [WIDTH-1:0] race_next;
    logic [WIDTH-1:0] entry;
    logic [CNT_W-1:0] cnt_next;

    // Per-bit NOR-latch truth table. Both outputs low in the hold case can only come from the forbidden state.
    always_comb begin
        q_next     = q;
        q_bar_next = q_bar;
        race_next  = '0;
        for (int i = 0; i < WIDTH; i++) begin
            unique case ({s[i], r[i]})
                2'b10: begin
                    q_next[i]     = 1'b1;
                    q_bar_next[i] = 1'b0;
                end
                2'b01: begin
                    q_next[i]     = 1'b0;
                    q_bar_next[i] = 1'b1;
                end
                2'b11: begin
                    q_next[i]     = 1'b0;
                    q_bar_next[i] = 1'b0;
                end
                default: begin
                    if (!q[i] && !q_bar[i]) begin
                        q_bar_next[i] = 1'b1;
                        race_next[i]  = 1'b1;
                    end
                end
            endcase
        end
    end

    // A bit enters forbidden when s=r=1 now but it was not forbidden in the previous cycle.
    always_comb begin
        entry = s & r & ~forbidden;
    end

    // Add one per entering bit and stop at all-ones so that the counter never wraps.
    always_comb begin
        cnt_next = forbid_cnt;
        for (int i = 0; i < WIDTH; i++) begin
            if (entry[i] && (cnt_next != CNT_MAX)) begin
                cnt_next = cnt_next + CNT_W'(1);
            end
        end
    end

    // Register all outputs. Reset takes priority and also clears the forbidden history.
    always_ff @(posedge clk) begin
        if (rst) begin
            q          <= '0;
            q_bar      <= '1;
            forbidden  <= '0;
            race       <= '0;
            err_sticky <= 1'b0;
            forbid_cnt <= '0;
        end else begin
            q          <= q_next;
            q_bar      <= q_bar_next;
            forbidden  <= s & r;
            race       <= race_next;
            err_sticky <= err_sticky | (|entry);
            forbid_cnt <= cnt_next;
        end
    end

endmodule

// File: tb/tb_sr_latch_nor.sv
// tb_sr_latch_nor: table-driven directed vectors, a hand-written corner sequence and
// randomized stimulus compared against a behavioural reference model.
module tb_sr_latch_nor;

    localparam int WIDTH = 4;
    localparam int CNT_W = 3;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    typedef struct {
        logic             rst;
        logic [WIDTH-1:0] s;
        logic [WIDTH-1:0] r;
        logic [WIDTH-1:0] q;
        logic [WIDTH-1:0] qb;
        logic [WIDTH-1:0] forb;
        logic [WIDTH-1:0] race;
        logic             err;
        logic [CNT_W-1:0] cnt;
    } vec_t;

    logic             clk;
    logic             rst;
    logic [WIDTH-1:0] s;
    logic [WIDTH-1:0] r;
    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] q_bar;
    logic [WIDTH-1:0] forbidden;
    logic [WIDTH-1:0] race;
    logic             err_sticky;
    logic [CNT_W-1:0] forbid_cnt;

    int checks = 0;
    int errors = 0;

    // Reference model state
    logic [WIDTH-1:0] m_q;
    logic [WIDTH-1:0] m_qb;
    logic [WIDTH-1:0] m_forb;
    logic [WIDTH-1:0] m_race;
    logic             m_err;
    int               m_cnt;

    vec_t vecs[27];

    sr_latch_nor #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clk(clk),
        .rst(rst),
        .s(s),
        .r(r),
        .q(q),
        .q_bar(q_bar),
        .forbidden(forbidden),
        .race(race),
        .err_sticky(err_sticky),
        .forbid_cnt(forbid_cnt)
    );

    // Free-running clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic vec_t mk(input logic rst_i, input logic [3:0] s_i, input logic [3:0] r_i,
                                input logic [3:0] q_i, input logic [3:0] qb_i, input logic [3:0] f_i,
                                input logic [3:0] race_i, input logic err_i, input logic [2:0] cnt_i);
        vec_t v;
        v.rst = rst_i; v.s = s_i; v.r = r_i; v.q = q_i; v.qb = qb_i;
        v.forb = f_i; v.race = race_i; v.err = err_i; v.cnt = cnt_i;
        return v;
    endfunction

    // Drive inputs on the falling edge, then let one rising edge pass and settle
    task automatic applyStimulus(input logic rst_i, input logic [WIDTH-1:0] s_i, input logic [WIDTH-1:0] r_i);
        @(negedge clk);
        rst = rst_i;
        s   = s_i;
        r   = r_i;
        @(posedge clk);
        #1;
    endtask

    task automatic cmp(input string tag, input string field, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s.%s got=%0h expected=%0h", tag, field, act, exp);
        end
    endtask

    task automatic checkOutput(input string tag, input vec_t e);
        cmp(tag, "q",          32'(q),          32'(e.q));
        cmp(tag, "q_bar",      32'(q_bar),      32'(e.qb));
        cmp(tag, "forbidden",  32'(forbidden),  32'(e.forb));
        cmp(tag, "race",       32'(race),       32'(e.race));
        cmp(tag, "err_sticky", 32'(err_sticky), 32'(e.err));
        cmp(tag, "forbid_cnt", 32'(forbid_cnt), 32'(e.cnt));
        cmp(tag, "legal",      32'(q & q_bar),  32'd0);
    endtask

    // Behavioural model: truth table per bit, counter as a clamped integer sum
    task automatic modelStep(input logic rst_i, input logic [WIDTH-1:0] s_i, input logic [WIDTH-1:0] r_i);
        int newly;
        if (rst_i) begin
            m_q = '0; m_qb = '1; m_forb = '0; m_race = '0; m_err = 1'b0; m_cnt = 0;
        end else begin
            newly  = $countones(s_i & r_i & ~m_forb);
            m_cnt  = (m_cnt + newly > CNT_MAX) ? CNT_MAX : m_cnt + newly;
            m_err  = m_err || (newly > 0);
            m_race = '0;
            for (int i = 0; i < WIDTH; i++) begin
                if (s_i[i] && r_i[i]) begin
                    m_q[i] = 1'b0; m_qb[i] = 1'b0;
                end else if (s_i[i]) begin
                    m_q[i] = 1'b1; m_qb[i] = 1'b0;
                end else if (r_i[i]) begin
                    m_q[i] = 1'b0; m_qb[i] = 1'b1;
                end else if (m_q[i] == 1'b0 && m_qb[i] == 1'b0) begin
                    m_qb[i] = 1'b1; m_race[i] = 1'b1;
                end
            end
            m_forb = s_i & r_i;
        end
    endtask

    initial begin
        vec_t e;
        logic             rr;
        logic [WIDTH-1:0] ss;
        logic [WIDTH-1:0] rv;

        rst = 1'b1;
        s   = '0;
        r   = '0;

        //                 rst  s     r     q     qb    forb  race  err  cnt
        vecs[0]  = mk(1'b1, 4'h0, 4'h0, 4'h0, 4'hF, 4'h0, 4'h0, 1'b0, 3'd0);
        vecs[1]  = mk(1'b0, 4'h1, 4'h0, 4'h1, 4'hE, 4'h0, 4'h0, 1'b0, 3'd0);
        vecs[2]  = mk(1'b0, 4'h0, 4'h0, 4'h1, 4'hE, 4'h0, 4'h0, 1'b0, 3'd0);
        vecs[3]  = mk(1'b0, 4'h0, 4'h0, 4'h1, 4'hE, 4'h0, 4'h0, 1'b0, 3'd0);
        vecs[4]  = mk(1'b0, 4'h0, 4'h0, 4'h1, 4'hE, 4'h0, 4'h0, 1'b0, 3'd0);
        vecs[5]  = mk(1'b0, 4'h0, 4'h1, 4'h0, 4'hF, 4'h0, 4'h0, 1'b0, 3'd0);
        vecs[6]  = mk(1'b0, 4'h0, 4'h0, 4'h0, 4'hF, 4'h0, 4'h0, 1'b0, 3'd0);
        vecs[7]  = mk(1'b0, 4'h1, 4'h1, 4'h0, 4'hE, 4'h1, 4'h0, 1'b1, 3'd1);
        vecs[8]  = mk(1'b0, 4'h0, 4'h0, 4'h0, 4'hF, 4'h0, 4'h1, 1'b1, 3'd1);
        vecs[9]  = mk(1'b0, 4'h0, 4'h0, 4'h0, 4'hF, 4'h0, 4'h0, 1'b1, 3'd1);
        vecs[10] = mk(1'b0, 4'h1, 4'h1, 4'h0, 4'hE, 4'h1, 4'h0, 1'b1, 3'd2);
        vecs[11] = mk(1'b0, 4'h1, 4'h1, 4'h0, 4'hE, 4'h1, 4'h0, 1'b1, 3'd2);
        vecs[12] = mk(1'b0, 4'h1, 4'h1, 4'h0, 4'hE, 4'h1, 4'h0, 1'b1, 3'd2);
        vecs[13] = mk(1'b0, 4'h1, 4'h1, 4'h0, 4'hE, 4'h1, 4'h0, 1'b1, 3'd2);
        vecs[14] = mk(1'b0, 4'h1, 4'h0, 4'h1, 4'hE, 4'h0, 4'h0, 1'b1, 3'd2);
        vecs[15] = mk(1'b1, 4'h1, 4'h0, 4'h0, 4'hF, 4'h0, 4'h0, 1'b0, 3'd0);
        vecs[16] = mk(1'b0, 4'hF, 4'hF, 4'h0, 4'h0, 4'hF, 4'h0, 1'b1, 3'd4);
        vecs[17] = mk(1'b0, 4'h0, 4'h0, 4'h0, 4'hF, 4'h0, 4'hF, 1'b1, 3'd4);
        vecs[18] = mk(1'b0, 4'hF, 4'hF, 4'h0, 4'h0, 4'hF, 4'h0, 1'b1, 3'd7);
        vecs[19] = mk(1'b0, 4'h0, 4'h0, 4'h0, 4'hF, 4'h0, 4'hF, 1'b1, 3'd7);
        vecs[20] = mk(1'b0, 4'hF, 4'hF, 4'h0, 4'h0, 4'hF, 4'h0, 1'b1, 3'd7);
        vecs[21] = mk(1'b0, 4'h0, 4'h0, 4'h0, 4'hF, 4'h0, 4'hF, 1'b1, 3'd7);
        vecs[22] = mk(1'b0, 4'h1, 4'h1, 4'h0, 4'hE, 4'h1, 4'h0, 1'b1, 3'd7);
        vecs[23] = mk(1'b1, 4'h1, 4'h1, 4'h0, 4'hF, 4'h0, 4'h0, 1'b0, 3'd0);
        vecs[24] = mk(1'b0, 4'h0, 4'h0, 4'h0, 4'hF, 4'h0, 4'h0, 1'b0, 3'd0);
        vecs[25] = mk(1'b0, 4'h0, 4'h0, 4'h0, 4'hF, 4'h0, 4'h0, 1'b0, 3'd0);
        vecs[26] = mk(1'b0, 4'hA, 4'h5, 4'hA, 4'h5, 4'h0, 4'h0, 1'b0, 3'd0);

        $display("[TB] directed vectors");
        for (int i = 0; i < 27; i++) begin
            applyStimulus(vecs[i].rst, vecs[i].s, vecs[i].r);
            checkOutput($sformatf("vec%0d", i), vecs[i]);
        end

        // Leaving forbidden through a reset request must not raise race
        $display("[TB] forbidden exit via reset request");
        applyStimulus(1'b1, 4'h0, 4'h0);
        applyStimulus(1'b0, 4'h4, 4'h4);
        checkOutput("exit_r_enter", mk(1'b0, 4'h4, 4'h4, 4'h0, 4'hB, 4'h4, 4'h0, 1'b1, 3'd1));
        applyStimulus(1'b0, 4'h0, 4'h4);
        checkOutput("exit_r_leave", mk(1'b0, 4'h0, 4'h4, 4'h0, 4'hF, 4'h0, 4'h0, 1'b1, 3'd1));
        applyStimulus(1'b0, 4'h0, 4'h0);
        checkOutput("exit_r_hold", mk(1'b0, 4'h0, 4'h0, 4'h0, 4'hF, 4'h0, 4'h0, 1'b1, 3'd1));

        $display("[TB] randomized stimulus");
        applyStimulus(1'b1, 4'h0, 4'h0);
        modelStep(1'b1, 4'h0, 4'h0);
        for (int n = 0; n < 400; n++) begin
            rr = ($urandom_range(0, 24) == 0);
            ss = WIDTH'($urandom);
            rv = WIDTH'($urandom);
            applyStimulus(rr, ss, rv);
            modelStep(rr, ss, rv);
            e = mk(rr, ss, rv, m_q, m_qb, m_forb, m_race, m_err, CNT_W'(m_cnt));
            checkOutput($sformatf("rand%0d", n), e);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/sr_latch_nor.md
# sr_latch_nor

Clocked, synchronous model of a cross-coupled NOR SR latch, replicated WIDTH times. Each bit follows the NOR-latch truth table: set, reset, hold and the both-outputs-low forbidden state. Leaving the forbidden state resolves deterministically, with no indeterminate output. Per-bit status flags and a saturating forbidden-event counter support debug. Used wherever the design needs SR-latch semantics on single-clock synchronous logic.

## Interface
- WIDTH, 1, number of independent latch bits (≥1)
- CNT_W, 8, width of the forbidden-event counter (≥1)

- clk  input  1  rising-edge clock; all state updates on this edge
- rst  input  1  synchronous, active-high reset
- s  input  WIDTH  set request per bit
- r  input  WIDTH  reset request per bit
- q  output  WIDTH  latch output
- q_bar  output  WIDTH  complementary latch output (NOR-latch semantics, not forced to ~q)
- forbidden  output  WIDTH  high while the bit sits in the S=R=1 state
- race  output  WIDTH  one-cycle pulse when a bit leaves S=R=1 directly to S=R=0
- err_sticky  output  1  set by any forbidden entry; cleared only by rst
- forbid_cnt  output  CNT_W  count of forbidden-state entries, saturating at all-ones

## Operation
- Per bit i, evaluated every rising clk edge when rst=0, from sampled s[i], r[i]:
  - s=1, r=0 (set): q=1, q_bar=0.
  - s=0, r=1 (reset): q=0, q_bar=1.
  - s=0, r=0 (hold): q and q_bar keep their values.
  - s=1, r=1 (forbidden): q=0, q_bar=0, forbidden=1.
- Holding from the forbidden state: if the previous cycle's (q,q_bar) was (0,0) and s=r=0, the bit resolves to q=0, q_bar=1 (reset-dominant) and race=1 for that cycle.
- Leaving forbidden via set or via reset follows the set/reset rows. race stays 0.
- forbidden[i] is a registered copy of (s[i] & r[i]).
- Entry detection: a bit enters forbidden when s=r=1 this cycle and it was not forbidden last cycle.
- forbid_cnt adds the number of bits entering forbidden this cycle (popcount) and saturates at 2^CNT_W−1. It never wraps.
- err_sticky is set on any entry and holds until rst.
- Bits are fully independent. Only forbid_cnt and err_sticky aggregate across bits.
- Legal states for (q,q_bar): (1,0), (0,1), (0,0). The state (1,1) must never appear.

## Timing
- All outputs are registered. Latency is one clk edge from sampled s/r to q, q_bar, forbidden, race, forbid_cnt and err_sticky.
- No combinational path from inputs to outputs.
- Reset (rst=1 at an edge) has priority over s/r: q=0, q_bar=1, forbidden=0, race=0, err_sticky=0, forbid_cnt=0.
- Reset mid-operation, including while forbidden, takes effect on that edge. The "previous forbidden" history is cleared, so the first hold after reset gives no race.
- Simultaneous entries on several bits in one cycle add their full popcount, clamped at saturation.
- race is exactly one cycle wide. It is 0 in every cycle not immediately following a forbidden cycle.

## Test plan
- After rst: set s=1,r=0 -> next edge q=1, q_bar=0, forbidden=0.
- s=0,r=0 after set -> q=1, q_bar=0 held for 3 edges. Then s=0,r=1 -> q=0, q_bar=1. Then s=0,r=0 -> q=0, q_bar=1 held.
- s=1,r=1 -> q=0, q_bar=0, forbidden=1, err_sticky=1, forbid_cnt=1. Then s=0,r=0 -> q=0, q_bar=1, race=1 for one cycle, forbidden=0.
- s=1,r=1 for 4 edges then s=1,r=0 -> forbid_cnt increments once only; then q=1, q_bar=0, race=0.
- WIDTH=4, CNT_W=3: drive s=r=4'b1111 and release, 3 times -> forbid_cnt saturates at 7, never wraps. rst -> all outputs at reset values.
- Assert rst while a bit is forbidden -> next edge q=0, q_bar=1, flags/counter 0. Hold s=r=0 -> race stays 0.
